// File: rtl/game_sprite_mover_pkg.sv
// Shared game configuration: screen geometry, coordinate widths and sprite coordinate types.
// Every game block imports this so that all sprites agree on the playfield.
package game_config;

    localparam int X_WIDTH       = 10;
    localparam int Y_WIDTH       = 10;
    localparam int D_WIDTH       = 4;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef logic [X_WIDTH-1:0] sprite_x_t;
    typedef logic [Y_WIDTH-1:0] sprite_y_t;
    typedef logic [D_WIDTH-1:0] sprite_d_t;

    function automatic sprite_x_t sext_x(input sprite_d_t d);
        return {{(X_WIDTH-D_WIDTH){d[D_WIDTH-1]}}, d};
    endfunction

    function automatic sprite_y_t sext_y(input sprite_d_t d);
        return {{(Y_WIDTH-D_WIDTH){d[D_WIDTH-1]}}, d};
    endfunction

endpackage

// File: rtl/game_sprite_mover_if.sv
// Control/status bundle between the game master FSM (master) and one sprite mover (slave).
// Display scan coordinates travel on the same bundle so the mixer side sees rgb_en alongside them.
interface game_sprite_mover_if;
    import game_config::*;

    logic      sprite_write_xy;
    sprite_x_t sprite_write_x;
    sprite_y_t sprite_write_y;
    logic      sprite_write_dxy;
    sprite_d_t sprite_write_dx;
    sprite_d_t sprite_write_dy;
    logic      sprite_enable_update;
    sprite_x_t pixel_x;
    sprite_y_t pixel_y;
    sprite_x_t sprite_x;
    sprite_y_t sprite_y;
    logic      sprite_within_screen;
    logic      sprite_rgb_en;

    modport master (
        output sprite_write_xy, sprite_write_x, sprite_write_y,
        output sprite_write_dxy, sprite_write_dx, sprite_write_dy,
        output sprite_enable_update, pixel_x, pixel_y,
        input  sprite_x, sprite_y, sprite_within_screen, sprite_rgb_en
    );

    modport slave (
        input  sprite_write_xy, sprite_write_x, sprite_write_y,
        input  sprite_write_dxy, sprite_write_dx, sprite_write_dy,
        input  sprite_enable_update, pixel_x, pixel_y,
        output sprite_x, sprite_y, sprite_within_screen, sprite_rgb_en
    );

endinterface

// File: rtl/game_sprite_mover_strobe_gen.sv
// Free-running modulo-PERIOD counter; strobe_o is high for the single cycle the count sits at PERIOD-1.
// Also used by the end-of-game timer, so it knows nothing about sprites.
module game_strobe_gen #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic strobe_o
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero after the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe_o = (cnt_q == LAST);

endmodule

// File: rtl/game_sprite_mover.sv
// Position/velocity engine for one sprite: moves on an internal tick, reports on-screen status
// and produces a registered per-pixel opacity flag from a 1-bit bitmap.
module game_sprite_mover
    import game_config::*;
#(
    parameter int UPDATE_PERIOD = 1000,
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter logic [SPRITE_WIDTH*SPRITE_HEIGHT-1:0] SPRITE_ROM = 64'hFF818181818181FF
) (
    input  logic                clk,
    input  logic                reset,
    game_sprite_mover_if.slave  bus
);

    localparam int        IDX_W  = $clog2(SPRITE_WIDTH * SPRITE_HEIGHT);
    localparam sprite_x_t X_MAX  = sprite_x_t'(SCREEN_WIDTH - SPRITE_WIDTH);
    localparam sprite_y_t Y_MAX  = sprite_y_t'(SCREEN_HEIGHT - SPRITE_HEIGHT);
    localparam sprite_x_t SPR_W  = sprite_x_t'(SPRITE_WIDTH);
    localparam sprite_y_t SPR_H  = sprite_y_t'(SPRITE_HEIGHT);

    sprite_x_t        x_q, x_d;
    sprite_y_t        y_q, y_d;
    sprite_d_t        dx_q, dx_d;
    sprite_d_t        dy_q, dy_d;
    logic             rgb_q, rgb_d;
    logic             tick_s;
    sprite_x_t        col_s;
    sprite_y_t        row_s;
    logic [IDX_W-1:0] idx_s;

    game_strobe_gen #(
        .PERIOD (UPDATE_PERIOD)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .strobe_o (tick_s)
    );

    // Position: an explicit load beats a motion tick; motion wraps modulo the register width.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (bus.sprite_write_xy) begin
            x_d = bus.sprite_write_x;
            y_d = bus.sprite_write_y;
        end else if (tick_s && bus.sprite_enable_update) begin
            x_d = x_q + sext_x(dx_q);
            y_d = y_q + sext_y(dy_q);
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Velocity: a load here only affects the next tick, the current one sees dx_q/dy_q.
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (bus.sprite_write_dxy) begin
            dx_d = bus.sprite_write_dx;
            dy_d = bus.sprite_write_dy;
        end else begin
            dx_d = dx_q;
            dy_d = dy_q;
        end
    end

    // Bitmap lookup: unsigned offsets make pixels left of / above the sprite look far away.
    always_comb begin
        col_s = bus.pixel_x - x_q;
        row_s = bus.pixel_y - y_q;
        idx_s = IDX_W'(32'(row_s) * SPRITE_WIDTH + 32'(col_s));
        rgb_d = 1'b0;
        if ((col_s < SPR_W) && (row_s < SPR_H)) begin
            rgb_d = SPRITE_ROM[idx_s];
        end else begin
            rgb_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            rgb_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            rgb_q <= rgb_d;
        end
    end

    assign bus.sprite_x             = x_q;
    assign bus.sprite_y             = y_q;
    assign bus.sprite_within_screen = (x_q <= X_MAX) && (y_q <= Y_MAX);
    assign bus.sprite_rgb_en        = rgb_q;

endmodule
